tournament_chooser: RTL and testbench



---
 rtl/tournament_chooser.sv | 134 +++++++++++++
 tb/tb_tournament_chooser.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_chooser.sv
// Tournament meta-predictor: per-entry saturating confidence counters pick one of N_PRED
// component predictions and are trained at resolve from an in-order snapshot FIFO. The
// optional global-history index folding is enabled with TOURNAMENT_CHOOSER_SEL_HIST_EN.
module tournament_chooser #(
  parameter int N_PRED = 2,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 8,
  parameter int GHR_W  = 4,
  localparam int PS_W  = (N_PRED > 2) ? $clog2(N_PRED) : 1,
  localparam int CNT_OUT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 predict_valid,
  input  logic [31:0]          predict_pc,
  input  logic [N_PRED-1:0]    comp_pred,
  output logic                 predict_ready,
  output logic                 prediction,
  output logic [PS_W-1:0]      pred_sel,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic                 flush,
  output logic [CNT_OUT_W-1:0] inflight_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRIES = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(1) << (CNT_W - 1);

  logic [CNT_W-1:0]  cnt [ENTRIES][N_PRED];
  logic [SEL_W-1:0]  fifo_idx  [DEPTH];
  logic [N_PRED-1:0] fifo_comp [DEPTH];
  logic [PS_W-1:0]   fifo_sel  [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;

  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  head_idx;
  logic [N_PRED-1:0] head_comp;
  logic              full, push, pop, agree;
  logic [CNT_W-1:0]  best;
  logic [PS_W-1:0]   sel_c;
  logic              unused_bits;

`ifdef TOURNAMENT_CHOOSER_SEL_HIST_EN
  logic [GHR_W-1:0] ghr;

  // History is non-speculative: it only advances on an accepted pop.
  always_ff @(posedge clk) begin
    if (rst)      ghr <= '0;
    else if (pop) ghr <= GHR_W'({ghr, resolve_taken});
  end

  assign idx = predict_pc[SEL_W+1:2] ^ SEL_W'(ghr);
`else
  assign idx = predict_pc[SEL_W+1:2];
`endif

  // Handshake: a snapshot is pushed only when predict_valid && predict_ready in the same
  // cycle; predict_ready depends solely on the registered count, so a same-cycle pop
  // never opens a slot in a full FIFO. resolve_valid has no ready and is ignored when empty.
  assign full           = (count == (PTR_W+1)'(DEPTH));
  assign predict_ready  = !full;
  assign push           = predict_valid && predict_ready && !flush;
  assign pop            = resolve_valid && (count != '0);
  assign inflight_count = CNT_OUT_W'(count);

  assign head_idx  = fifo_idx[head];
  assign head_comp = fifo_comp[head];
  assign agree     = (head_comp == '0) || (head_comp == '1);

  // Strict greater-than keeps ties on the lowest component index.
  always_comb begin
    best  = cnt[idx][0];
    sel_c = '0;
    for (int i = 1; i < N_PRED; i++) begin
      if (cnt[idx][i] > best) begin
        best  = cnt[idx][i];
        sel_c = PS_W'(i);
      end
    end
  end

  assign pred_sel   = sel_c;
  assign prediction = comp_pred[sel_c];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_idx[tail]  <= idx;
      fifo_comp[tail] <= comp_pred;
      fifo_sel[tail]  <= sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) begin
        for (int i = 0; i < N_PRED; i++) begin
          cnt[e][i] <= (i == 0) ? CNT_MID : CNT_MID - CNT_W'(1);
        end
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop && !agree) begin
        for (int i = 0; i < N_PRED; i++) begin
          if (head_comp[i] == resolve_taken) begin
            if (cnt[head_idx][i] != '1) cnt[head_idx][i] <= cnt[head_idx][i] + CNT_W'(1);
          end else begin
            if (cnt[head_idx][i] != '0) cnt[head_idx][i] <= cnt[head_idx][i] - CNT_W'(1);
          end
        end
      end
      // A flush still lets the same-cycle pop train, then empties the FIFO.
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign unused_bits = ^{predict_pc[31:SEL_W+2], predict_pc[1:0], fifo_sel[head], best};

endmodule

// File: tb/tb_tournament_chooser.sv
// Directed bench for tournament_chooser (N_PRED=2, SEL_W=2, CNT_W=4, DEPTH=4), default build.
module tb_tournament_chooser;
  localparam int N_PRED = 2;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int GHR_W  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        predict_valid;
  logic [31:0] predict_pc;
  logic [1:0]  comp_pred;
  logic        predict_ready;
  logic        prediction;
  logic [0:0]  pred_sel;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        flush;
  logic [2:0]  inflight_count;

  int tests_run    = 0;
  int tests_failed = 0;

  tournament_chooser #(
    .N_PRED(N_PRED), .SEL_W(SEL_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .predict_valid(predict_valid), .predict_pc(predict_pc), .comp_pred(comp_pred),
    .predict_ready(predict_ready), .prediction(prediction), .pred_sel(pred_sel),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .inflight_count(inflight_count)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    predict_valid = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] comp);
    predict_pc    = pc;
    comp_pred     = comp;
    predict_valid = 1'b1;
    step();
    predict_valid = 1'b0;
  endtask

  task automatic resolve(input logic taken);
    resolve_taken = taken;
    resolve_valid = 1'b1;
    step();
    resolve_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    idle();
    resolve_taken = 1'b0;
    predict_pc    = 32'h10;
    comp_pred     = 2'b10;
    step();
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if (pred_sel !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pred_sel: got %0d expected 0", pred_sel);
    end
    tests_run++;
    if (prediction !== 1'b0) begin
      tests_failed++; $display("FAIL reset_prediction: got %0b expected 0", prediction);
    end
    tests_run++;
    if (predict_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %0b expected 1", predict_ready);
    end
    tests_run++;
    if (inflight_count !== 3'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d expected 0", inflight_count);
    end
    tests_run++;
    if (dut.cnt[0][0] !== 4'd8 || dut.cnt[2][1] !== 4'd7) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %0d/%0d expected 8/7", dut.cnt[0][0], dut.cnt[2][1]);
    end
  endtask

  task automatic test_train();
    for (int k = 0; k < 3; k++) begin
      push(32'h0, 2'b10);
      resolve(1'b1);
      if (k == 0) begin
        predict_pc = 32'h0;
        comp_pred  = 2'b10;
        #1;
        tests_run++;
        if (pred_sel !== 1'b1 || prediction !== 1'b1) begin
          tests_failed++;
          $display("FAIL train_first_sel: got sel=%0d pred=%0b expected sel=1 pred=1", pred_sel, prediction);
        end
      end
    end
    tests_run++;
    if (dut.cnt[0][0] !== 4'd5 || dut.cnt[0][1] !== 4'd10) begin
      tests_failed++;
      $display("FAIL train_cnt: got %0d/%0d expected 5/10", dut.cnt[0][0], dut.cnt[0][1]);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) push(32'h4, 2'b01);
    tests_run++;
    if (predict_ready !== 1'b0 || inflight_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_state: got ready=%0b count=%0d expected ready=0 count=4", predict_ready, inflight_count);
    end
    push(32'h4, 2'b01);
    tests_run++;
    if (inflight_count !== 3'd4) begin
      tests_failed++; $display("FAIL full_drop: got %0d expected 4", inflight_count);
    end
    // Pop plus push while full: the push is refused.
    predict_valid = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0;
    step();
    tests_run++;
    if (inflight_count !== 3'd3) begin
      tests_failed++; $display("FAIL full_pop_push: got %0d expected 3", inflight_count);
    end
    step();
    idle();
    tests_run++;
    if (inflight_count !== 3'd3) begin
      tests_failed++; $display("FAIL simul_push_pop: got %0d expected 3", inflight_count);
    end
    push(32'h4, 2'b01);
    tests_run++;
    if (inflight_count !== 3'd4) begin
      tests_failed++; $display("FAIL refill: got %0d expected 4", inflight_count);
    end
    for (int k = 0; k < 4; k++) resolve(1'b0);
    tests_run++;
    if (inflight_count !== 3'd0 || dut.cnt[1][0] !== 4'd2 || dut.cnt[1][1] !== 4'd13) begin
      tests_failed++;
      $display("FAIL drain: got count=%0d cnt=%0d/%0d expected count=0 cnt=2/13",
               inflight_count, dut.cnt[1][0], dut.cnt[1][1]);
    end
    resolve(1'b1);
    tests_run++;
    if (inflight_count !== 3'd0 || dut.cnt[1][0] !== 4'd2 || dut.cnt[1][1] !== 4'd13) begin
      tests_failed++;
      $display("FAIL empty_resolve: got count=%0d cnt=%0d/%0d expected count=0 cnt=2/13",
               inflight_count, dut.cnt[1][0], dut.cnt[1][1]);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      push(32'h8, 2'b10);
      resolve(1'b1);
    end
    tests_run++;
    if (dut.cnt[2][0] !== 4'd0 || dut.cnt[2][1] !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_cnt: got %0d/%0d expected 0/15", dut.cnt[2][0], dut.cnt[2][1]);
    end
    push(32'h8, 2'b10);
    resolve(1'b1);
    tests_run++;
    if (dut.cnt[2][0] !== 4'd0 || dut.cnt[2][1] !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d/%0d expected 0/15", dut.cnt[2][0], dut.cnt[2][1]);
    end
    predict_pc = 32'h8; comp_pred = 2'b01;
    #1;
    tests_run++;
    if (pred_sel !== 1'b1 || prediction !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_choose: got sel=%0d pred=%0b expected sel=1 pred=0", pred_sel, prediction);
    end
  endtask

  task automatic test_agree();
    push(32'hC, 2'b11);
    resolve(1'b0);
    tests_run++;
    if (dut.cnt[3][0] !== 4'd8 || dut.cnt[3][1] !== 4'd7 || inflight_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL agree: got cnt=%0d/%0d count=%0d expected cnt=8/7 count=0",
               dut.cnt[3][0], dut.cnt[3][1], inflight_count);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) push(32'hC, 2'b10);
    predict_pc = 32'hC; comp_pred = 2'b10;
    predict_valid = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; flush = 1'b1;
    step();
    idle();
    tests_run++;
    if (inflight_count !== 3'd0 || predict_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty: got count=%0d ready=%0b expected count=0 ready=1", inflight_count, predict_ready);
    end
    tests_run++;
    if (dut.cnt[3][0] !== 4'd7 || dut.cnt[3][1] !== 4'd8) begin
      tests_failed++;
      $display("FAIL flush_train: got %0d/%0d expected 7/8", dut.cnt[3][0], dut.cnt[3][1]);
    end
    resolve(1'b1);
    tests_run++;
    if (dut.cnt[3][0] !== 4'd7 || dut.cnt[3][1] !== 4'd8 || inflight_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_ignore: got cnt=%0d/%0d count=%0d expected cnt=7/8 count=0",
               dut.cnt[3][0], dut.cnt[3][1], inflight_count);
    end
    // A fresh entry must be the one trained, not a stale pre-flush snapshot.
    push(32'hC, 2'b01);
    resolve(1'b1);
    tests_run++;
    if (dut.cnt[3][0] !== 4'd8 || dut.cnt[3][1] !== 4'd7) begin
      tests_failed++;
      $display("FAIL flush_fresh: got %0d/%0d expected 8/7", dut.cnt[3][0], dut.cnt[3][1]);
    end
  endtask

  task automatic test_reset_mid();
    push(32'h0, 2'b10);
    push(32'h0, 2'b10);
    rst = 1'b1; predict_valid = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    tests_run++;
    if (inflight_count !== 3'd0 || dut.cnt[0][0] !== 4'd8 || dut.cnt[0][1] !== 4'd7
        || dut.cnt[2][1] !== 4'd7) begin
      tests_failed++;
      $display("FAIL reset_mid: got count=%0d cnt=%0d/%0d/%0d expected count=0 cnt=8/7/7",
               inflight_count, dut.cnt[0][0], dut.cnt[0][1], dut.cnt[2][1]);
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_train();
    test_full();
    test_saturation();
    test_agree();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
